// File: rtl/ecnu_rv_pkg.sv
// rtl/ecnu_rv_pkg.sv - shared RV constants and the fetch buffer entry type
package ecnu_rv_pkg;
  localparam int XLEN    = 32;
  localparam int ILEN    = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/ifu_if.sv
// rtl/ifu_if.sv - fetch unit bundle: imem request/response, redirect and decode handoff
interface ifu_if;
  import ecnu_rv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [ILEN-1:0] instr_out;
  logic [XLEN-1:0] instr_pc;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr_out, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr_out, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - circular instruction buffer with flush; head is read from registered storage
module ifu_fifo
  import ecnu_rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               wdata,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            pop_ok;
  logic            push_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && ((count_q != CW'(DEPTH)) || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      // a pop in the flush cycle has already been consumed by decode
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: PC, credit-based imem requests, redirect flush
// IFU_PERF_CNT_EN adds perf_fetch_cnt/perf_flush_cnt outputs.
module ifu
  import ecnu_rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  ifu_if.master       bus
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rsp_pc_q;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   drop_q;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   fifo_count;
  logic [CW+1:0]   credit_used;
  logic            run_q;
  logic            pop;
  logic            req_fire;
  logic            rsp_fire;
  logic            keep;
  logic [XLEN-1:0] target;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign target   = word_align(bus.redirect_pc);
  assign pop      = bus.instr_valid && bus.instr_ready;
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_fire = bus.imem_rsp_valid;
  assign keep     = rsp_fire && (drop_q == '0) && !bus.redirect_valid;

  // every in-flight request owns a buffer slot, so the FIFO can never overflow
  assign credit_used = (CW+2)'(outstanding_q) + (CW+2)'(fifo_count) - (CW+2)'(pop);
  assign bus.imem_req_valid = run_q && !bus.redirect_valid && (credit_used < (CW+2)'(FIFO_DEPTH));
  assign bus.imem_addr      = pc_q;

  assign outstanding_next = outstanding_q + CW'(req_fire) - CW'(rsp_fire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q         <= 1'b0;
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      run_q         <= 1'b1;
      outstanding_q <= outstanding_next;
      if (bus.redirect_valid) begin
        pc_q     <= target;
        rsp_pc_q <= target;
        // everything still in flight after this edge belongs to the old path
        drop_q   <= outstanding_next;
      end else begin
        if (req_fire) pc_q <= pc_q + XLEN'(PC_STEP);
        if (keep) rsp_pc_q <= rsp_pc_q + XLEN'(PC_STEP);
        if (rsp_fire && (drop_q != '0)) drop_q <= drop_q - CW'(1);
      end
    end
  end

  assign push_entry = '{instr: bus.imem_rdata, pc: rsp_pc_q};

  ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (keep),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .wdata (push_entry),
    .head  (head),
    .count (fifo_count)
  );

  assign bus.instr_valid = (fifo_count != '0);
  assign bus.instr_out   = head.instr;
  assign bus.instr_pc    = head.pc;

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pop) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (bus.redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`else
`endif
endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - directed vector bench for ifu with an in-order imem model and decode scoreboard
module tb_ifu;
  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic clk;
  logic rst_n;

  ifu_if m_if ();
  ifu_if w_if ();

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt, w_pf, w_pl;
`endif

  ifu #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  ifu #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (w_if)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (w_pf),
    .perf_flush_cnt (w_pl)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        ir;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic        e_wreq;
    logic [31:0] e_waddr;
  } vec_t;

  mreq_t       memq[$];
  vec_t        vt[14];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat = 1;
  int          pops = 0;
  int          flushes = 0;
  logic [31:0] exp_pc = 32'h100;
  logic        s_req, s_iv, s_wreq;
  logic [31:0] s_addr, s_out, s_pc, s_waddr;
  logic        found;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_sample();
    if (memq.size() != 0 && memq[0].due <= cyc) begin
      m_if.imem_rsp_valid = 1'b1;
      m_if.imem_rdata     = memq[0].addr ^ KEY;
    end else begin
      m_if.imem_rsp_valid = 1'b0;
      m_if.imem_rdata     = '0;
    end
    #1;
    s_req   = m_if.imem_req_valid;
    s_addr  = m_if.imem_addr;
    s_iv    = m_if.instr_valid;
    s_out   = m_if.instr_out;
    s_pc    = m_if.instr_pc;
    s_wreq  = w_if.imem_req_valid;
    s_waddr = w_if.imem_addr;
    if (s_req) check("addr_align", {30'd0, s_addr[1:0]}, 32'd0);
    if (s_iv && m_if.instr_ready) begin
      check("sb_pc", s_pc, exp_pc);
      check("sb_instr", s_out, exp_pc ^ KEY);
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (m_if.redirect_valid) begin
      exp_pc = m_if.redirect_pc & ~32'h3;
      flushes++;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (m_if.imem_rsp_valid) memq.delete(0);
    if (s_req && m_if.imem_req_ready) memq.push_back('{addr: s_addr, due: cyc + lat});
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // cycle-by-cycle trace with 1-cycle memory, then 5 cycles of decode stall
    vt[0]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h000, 1'b1, 32'hFFFF_FFFC};
    vt[1]  = '{1'b1, 1'b1, 32'h104, 1'b0, 32'h000, 1'b1, 32'h0000_0000};
    vt[2]  = '{1'b1, 1'b1, 32'h108, 1'b1, 32'h100, 1'b0, 32'h0000_0004};
    vt[3]  = '{1'b1, 1'b1, 32'h10C, 1'b1, 32'h104, 1'b0, 32'h0000_0004};
    vt[4]  = '{1'b1, 1'b1, 32'h110, 1'b1, 32'h108, 1'b0, 32'h0000_0004};
    vt[5]  = '{1'b0, 1'b0, 32'h114, 1'b1, 32'h10C, 1'b0, 32'h0000_0004};
    vt[6]  = '{1'b0, 1'b0, 32'h114, 1'b1, 32'h10C, 1'b0, 32'h0000_0004};
    vt[7]  = '{1'b0, 1'b0, 32'h114, 1'b1, 32'h10C, 1'b0, 32'h0000_0004};
    vt[8]  = '{1'b0, 1'b0, 32'h114, 1'b1, 32'h10C, 1'b0, 32'h0000_0004};
    vt[9]  = '{1'b0, 1'b0, 32'h114, 1'b1, 32'h10C, 1'b0, 32'h0000_0004};
    vt[10] = '{1'b1, 1'b1, 32'h114, 1'b1, 32'h10C, 1'b0, 32'h0000_0004};
    vt[11] = '{1'b1, 1'b1, 32'h118, 1'b1, 32'h110, 1'b0, 32'h0000_0004};
    vt[12] = '{1'b1, 1'b1, 32'h11C, 1'b1, 32'h114, 1'b0, 32'h0000_0004};
    vt[13] = '{1'b1, 1'b1, 32'h120, 1'b1, 32'h118, 1'b0, 32'h0000_0004};

    rst_n = 1'b0;
    m_if.imem_req_ready = 1'b1; m_if.imem_rsp_valid = 1'b0; m_if.imem_rdata = '0;
    m_if.redirect_valid = 1'b0; m_if.redirect_pc = '0; m_if.instr_ready = 1'b1;
    w_if.imem_req_ready = 1'b1; w_if.imem_rsp_valid = 1'b0; w_if.imem_rdata = '0;
    w_if.redirect_valid = 1'b0; w_if.redirect_pc = '0; w_if.instr_ready = 1'b1;

    @(negedge clk);
    drive_sample();
    check("rst_req_valid", {31'd0, s_req}, 32'd0);
    check("rst_instr_valid", {31'd0, s_iv}, 32'd0);
    check("rst_addr", s_addr, 32'h100);
    check("rst_instr_out", s_out, 32'd0);
    check("rst_instr_pc", s_pc, 32'd0);
    check("rst_wrap_addr", s_waddr, 32'hFFFF_FFFC);
    advance();
    rst_n = 1'b1;
    advance();

    for (int i = 0; i < 14; i++) begin
      m_if.instr_ready = vt[i].ir;
      drive_sample();
      check($sformatf("v%0d_req", i), {31'd0, s_req}, {31'd0, vt[i].e_req});
      check($sformatf("v%0d_addr", i), s_addr, vt[i].e_addr);
      check($sformatf("v%0d_iv", i), {31'd0, s_iv}, {31'd0, vt[i].e_iv});
      if (vt[i].e_iv) begin
        check($sformatf("v%0d_pc", i), s_pc, vt[i].e_pc);
        check($sformatf("v%0d_instr", i), s_out, vt[i].e_pc ^ KEY);
      end
      check($sformatf("v%0d_wreq", i), {31'd0, s_wreq}, {31'd0, vt[i].e_wreq});
      check($sformatf("v%0d_waddr", i), s_waddr, vt[i].e_waddr);
      advance();
    end

    // redirect coinciding with a response and a pop
    m_if.instr_ready = 1'b1;
    m_if.redirect_valid = 1'b1;
    m_if.redirect_pc = 32'h0000_3001;
    drive_sample();
    check("co_rsp_present", {31'd0, m_if.imem_rsp_valid}, 32'd1);
    check("co_pop", {31'd0, s_iv}, 32'd1);
    check("co_req_gated", {31'd0, s_req}, 32'd0);
    advance();
    m_if.redirect_valid = 1'b0;
    drive_sample();
    check("co_empty", {31'd0, s_iv}, 32'd0);
    check("co_req", {31'd0, s_req}, 32'd1);
    check("co_addr", s_addr, 32'h3000);
    advance();
    drive_sample();
    check("co_empty2", {31'd0, s_iv}, 32'd0);
    advance();
    drive_sample();
    check("co_first_valid", {31'd0, s_iv}, 32'd1);
    check("co_first_pc", s_pc, 32'h3000);
    advance();

    // redirect with two requests in flight under a slower memory
    lat = 4;
    for (int k = 0; k < 20 && memq.size() < 2; k++) begin
      drive_sample();
      advance();
    end
    check("inflight2", memq.size(), 32'd2);
    m_if.redirect_valid = 1'b1;
    m_if.redirect_pc = 32'h0000_2002;
    drive_sample();
    check("rd_req_gated", {31'd0, s_req}, 32'd0);
    advance();
    m_if.redirect_valid = 1'b0;
    drive_sample();
    check("rd_addr", s_addr, 32'h2000);
    advance();
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      drive_sample();
      if (s_iv) begin
        found = 1'b1;
        break;
      end
      advance();
    end
    check("rd_delivered", {31'd0, found}, 32'd1);
    check("rd_first_pc", s_pc, 32'h2000);
    advance();

    // mixed decode stalls with one more redirect
    lat = 1;
    for (int k = 0; k < 16; k++) begin
      m_if.instr_ready = 1'($urandom_range(0, 1));
      m_if.redirect_valid = (k == 8);
      m_if.redirect_pc = 32'h0000_0040;
      drive_sample();
      advance();
    end
    m_if.redirect_valid = 1'b0;
    m_if.instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive_sample();
      advance();
    end

`ifdef IFU_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, pops);
    check("perf_flush", perf_flush_cnt, flushes);
`endif

    // asynchronous reset in the middle of a cycle
    drive_sample();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, m_if.imem_req_valid}, 32'd0);
    check("mid_rst_iv", {31'd0, m_if.instr_valid}, 32'd0);
    check("mid_rst_addr", m_if.imem_addr, 32'h100);
    check("mid_rst_instr", m_if.instr_out, 32'd0);
    memq.delete();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit that sits directly upstream of the decode stage. It owns the program counter and issues word-aligned fetches to instruction memory over a valid/ready request and in-order response interface. Returned instructions are buffered in a small FIFO and presented to decode with their PC. Branch and jump redirects from execute flush all in-flight work.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset.
- `FIFO_DEPTH`, default `2`: instruction buffer entries; also the maximum number of requests in flight. Must be at least 2.

- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_addr` out 32: fetch address; bits [1:0] are always 0.
- `imem_rsp_valid` in 1: response valid. Responses arrive in order, at least 1 cycle after acceptance, with at most 1 per cycle.
- `imem_rdata` in 32: fetched instruction word.
- `redirect_valid` in 1: taken branch, jal or jalr.
- `redirect_pc` in 32: redirect target; bits [1:0] are ignored and forced to 0.
- `instr_valid` out 1: instruction available to decode.
- `instr_ready` in 1: decode consumes the instruction.
- `instr_out` out 32: instruction word (the decode `instr_in`).
- `instr_pc` out 32: PC of `instr_out`.

## Operation
- Reset values:
  - `pc_q` = `RESET_PC`
  - FIFO empty
  - outstanding = 0, drop = 0
  - `imem_req_valid` = 0, `instr_valid` = 0
  - `instr_out` = 0, `instr_pc` = 0
  - `imem_addr` = `RESET_PC`
- `imem_addr` = `pc_q`.
- **Request issue.** `imem_req_valid` = !`redirect_valid` && (outstanding + count − pop < `FIFO_DEPTH`).
  - pop = `instr_valid` && `instr_ready`.
  - outstanding includes requests whose responses will be dropped.
- **Request handshake** (valid && ready): `pc_q` += 4 (wraps modulo 2^32), outstanding++.
- **Response handshake:** outstanding--.
  - If drop > 0: drop-- and the data is discarded.
  - Otherwise {`imem_rdata`, PC} is written to the FIFO. The PC comes from an internal response-PC register advanced by 4 per kept response.
- **Redirect** (single-cycle pulse, highest priority):
  - `pc_q` and the response-PC register both load `redirect_pc` & ~3.
  - The FIFO is cleared.
  - drop := outstanding after this cycle's updates, so responses and requests handshaked in the redirect cycle are also dropped.
- **Simultaneous events:**
  - A pop in the redirect cycle completes normally; decode owns it.
  - A response in the redirect cycle is discarded.
  - No request is raised in the redirect cycle. If memory nonetheless sees a stale `imem_req_valid` it cannot, because valid is combinationally gated by `redirect_valid`.
  - FIFO push and pop in the same cycle leave count unchanged.
- **FIFO full** cannot overflow: the credit rule reserves a slot for every outstanding request.
- **Reset mid-operation** returns everything to reset values. Responses for pre-reset requests must not arrive; this is the memory's responsibility.
- **Backpressure:** while `instr_valid` && !`instr_ready`, `instr_out` and `instr_pc` hold stable.

## Timing
- Registered FIFO output, so there is no combinational path from `imem_rdata` to `instr_out`.
- Minimum path with a 1-cycle memory:
  - Redirect in cycle 0.
  - Request with the new address in cycle 1.
  - Response in cycle 2.
  - `instr_valid` in cycle 3.
- Steady state at `FIFO_DEPTH` = 2 with a 1-cycle memory and decode always ready: 1 instruction per cycle.
- First request after reset: `imem_req_valid` rises in the first cycle after `rst_n` deasserts.
- Combinational paths:
  - `redirect_valid` → `imem_req_valid`.
  - `instr_ready` → `imem_req_valid` (credit).

## Configuration
- `IFU_PERF_CNT_EN` defined: adds outputs `perf_fetch_cnt` [31:0] and `perf_flush_cnt` [31:0].
  - `perf_fetch_cnt` counts pops; `perf_flush_cnt` counts redirects.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

## Structure
- The shared package `ecnu_rv_pkg` holds:
  - `XLEN` = 32
  - `ILEN` = 32
  - `PC_STEP` = 4
  - the `fetch_entry_t` struct {instr, pc}
- One sub-module, `ifu_fifo`:
  - parameterised synchronous FIFO of `fetch_entry_t`
  - ports: push, pop, flush, count
  - registered head output

## Test plan
- **Reset:** `RESET_PC`=0x100, memory always ready, 1-cycle latency → addresses 0x100, 0x104, 0x108…; decode sees {instr, pc} pairs in order at 1 per cycle.
- **Backpressure:** hold `instr_ready`=0 for 5 cycles → at most 2 requests outstanding or buffered, `instr_out` stable, no words lost after release.
- **Redirect:** redirect to 0x2002 with 2 requests in flight → both responses dropped, next `imem_addr`=0x2000, first delivered `instr_pc`=0x2000.
- **Coincident redirect:** redirect in the same cycle as a response and a pop → the popped instruction is delivered once, the response is discarded, and the FIFO is empty next cycle.
- **Wrap-around:** `RESET_PC`=0xFFFF_FFFC → next fetch address 0x0000_0000.
- **Perf counters:** with `IFU_PERF_CNT_EN`, 10 pops and 3 redirects → `perf_fetch_cnt`=10, `perf_flush_cnt`=3.
